pixel_shift_sequencer: RTL
==========================

# pixel_shift_sequencer

Controller for the multi-frame pixel-shift capture path. It steps the sensor actuator through a fixed set of sub-pixel shift positions and waits for mechanical settle at each one. It then triggers one RGB frame capture and streams that frame into the pixel-shift combiner. The stream is a raster walk of `pixel_counter_x`/`pixel_counter_y` under a valid/ready handshake. It sits in the top-level image pipeline, between the capture block and the combiner.

## Interface
- `IMG_W`, 64: frame width in pixels (≥2).
- `IMG_H`, 64: frame height in pixels (≥2).
- `SHIFT_POS`, 4: number of shift positions per sequence (1..16).
- `SETTLE_CYCLES`, 16: wait cycles after actuator ack (≥1).
- `ACK_TIMEOUT`, 1024: maximum cycles to wait for `shift_ack` or `capture_done`.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: start a sequence; sampled only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `shift_req` out 1: actuator move request; held until ack.
- `shift_pos` out clog2(SHIFT_POS) (min 1): target position; stable while `shift_req`=1.
- `shift_ack` in 1: actuator reached the position.
- `capture_start` out 1: one-cycle pulse to the capture block.
- `capture_done` in 1: frame is held in the capture block.
- `pixel_valid` out 1: pixel address valid toward the combiner.
- `pixel_ready` in 1: combiner accepts the current pixel.
- `pixel_counter_x` out clog2(IMG_W): column address.
- `pixel_counter_y` out clog2(IMG_H): row address.
- `last_pixel` out 1: high with `pixel_valid` on pixel (IMG_W-1, IMG_H-1).
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when the sequence completes.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.

## Operation
States and transitions:
- IDLE: `start` → MOVE. Clears position index, counters, `error`.
- MOVE: drive `shift_req`=1 and `shift_pos`=index.
  - `shift_ack` → SETTLE; `shift_req` drops in the same cycle the state changes.
- SETTLE: count SETTLE_CYCLES, then → CAPTURE.
- CAPTURE: pulse `capture_start` on entry cycle only.
  - `capture_done` → STREAM.
- STREAM: `pixel_valid`=1. Each cycle with `pixel_valid`&`pixel_ready` advances the raster.
  - x increments; at IMG_W-1, x wraps to 0 and y increments.
  - Transfer of the last pixel → NEXT. x and y return to 0.
- NEXT: index == SHIFT_POS-1 → DONE; otherwise index+1 → MOVE.
- DONE: `done`=1 for one cycle → IDLE.

Timeout: one shared wait counter, cleared on every state entry.
- In MOVE or CAPTURE, reaching ACK_TIMEOUT without the expected input sets `error` and goes to IDLE.
- No timeout in STREAM; backpressure is unbounded.

Abort:
- `abort`=1 in any state → IDLE next cycle. `error` is not set.
- Abort has priority over `start`, acks and transfers in the same cycle.
- A pixel presented in the abort cycle with `pixel_ready`=1 does not count as transferred.

Boundary rules:
- `shift_ack` or `capture_done` outside its own state is ignored.
- `start` while busy is ignored.
- SHIFT_POS=1: a single MOVE→…→NEXT→DONE pass.
- Address outputs hold while `pixel_ready`=0.

## Timing
- Reset values: every output is 0. State is IDLE. Index, counters and `error` are 0.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- `start` → `shift_req` high: 1 cycle.
- `shift_ack` sampled high → `shift_req` low and SETTLE entered on the next edge.
- SETTLE occupies exactly SETTLE_CYCLES cycles. `capture_start` rises on the cycle after SETTLE ends.
- `capture_done` → `pixel_valid` high: 1 cycle.
- Stream throughput: 1 pixel/cycle with `pixel_ready` held high. A frame takes IMG_W×IMG_H cycles.
- Reset asserted mid-sequence: outputs go to 0 asynchronously. The sequencer restarts only on a new `start`.

## Structure
- Shared package `pixel_shift_pkg` holds:
  - state enum: IDLE, MOVE, SETTLE, CAPTURE, STREAM, NEXT, DONE;
  - width constants derived from IMG_W, IMG_H, SHIFT_POS.
- One sub-module, `raster_counter`: x/y counter with enable, wrap and `last` flag. It is reusable by other frame walkers.
- The FSM, the wait/timeout counter and the position index stay in the top module.

## Test plan
- Nominal run (IMG_W=4, IMG_H=2, SHIFT_POS=4, SETTLE_CYCLES=3):
  - Stimulus: ack and capture_done after 2 cycles each; `pixel_ready`=1.
  - Response: `shift_pos` takes 0,1,2,3; exactly 4 `capture_start` pulses; 32 pixel transfers in raster order; one `done` pulse; `error`=0.
- Backpressure:
  - Stimulus: `pixel_ready` toggles 1/0 every cycle.
  - Response: each (x,y) is transferred once; addresses hold during 0 cycles; frame takes 16 cycles for 4×2; `last_pixel` only at (3,1).
- Ack timeout:
  - Stimulus: ACK_TIMEOUT=8; never assert `shift_ack`.
  - Response: `error`=1 and IDLE after 8 MOVE cycles; no `capture_start`; next `start` clears `error`.
- Abort mid-stream:
  - Stimulus: assert `abort` at pixel (2,0) with `pixel_ready`=1.
  - Response: IDLE next cycle; `pixel_valid`=0; counters 0; no `done`; `error`=0.
- Async reset in SETTLE:
  - Stimulus: assert `reset_n`=0 between clock edges.
  - Response: all outputs 0 immediately; after release, nothing happens until `start`.
- Spurious inputs:
  - Stimulus: `capture_done` pulse during MOVE; `start` during STREAM.
  - Response: both ignored; sequence completes normally.

Source files
------------

// File: rtl/pixel_shift_pkg.sv
// Shared types and width helpers for the pixel-shift capture sequencer.
package pixel_shift_pkg;

  // Sequencer states, in the order a nominal pass visits them.
  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SETTLE,
    CAPTURE,
    STREAM,
    NEXT,
    DONE
  } state_t;

  localparam int DEF_IMG_W         = 64;
  localparam int DEF_IMG_H         = 64;
  localparam int DEF_SHIFT_POS     = 4;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT   = 1024;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_shift_sequencer_raster.sv
// Raster x/y walker: x runs fastest, both wrap to 0 after (W-1, H-1).
// 'last' flags the final pixel of the frame from the registered counters.
module raster_counter
  import pixel_shift_pkg::*;
#(
  parameter int W = DEF_IMG_W,
  parameter int H = DEF_IMG_H
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     enable,
  output logic [width_of(W)-1:0]   x,
  output logic [width_of(H)-1:0]   y,
  output logic                     last
);

  localparam int XW = width_of(W);
  localparam int YW = width_of(H);
  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // Advance one pixel per enabled cycle; clear has priority over enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + Y_ONE;
      end else begin
        x <= x + X_ONE;
      end
    end
  end

endmodule

// File: rtl/pixel_shift_sequencer.sv
// Pixel-shift capture sequencer: move actuator, settle, capture one frame,
// stream its pixel addresses to the combiner, repeat for every position.
//
// Pixel handshake: a pixel (pixel_counter_x, pixel_counter_y) is transferred
// on a rising clock edge where pixel_valid and pixel_ready are both 1 and
// abort is 0; while pixel_ready is 0 the address holds and pixel_valid stays
// high. pixel_valid never depends combinationally on pixel_ready.
module pixel_shift_sequencer
  import pixel_shift_pkg::*;
#(
  parameter int IMG_W         = DEF_IMG_W,
  parameter int IMG_H         = DEF_IMG_H,
  parameter int SHIFT_POS     = DEF_SHIFT_POS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             abort,
  output logic                             shift_req,
  output logic [width_of(SHIFT_POS)-1:0]   shift_pos,
  input  logic                             shift_ack,
  output logic                             capture_start,
  input  logic                             capture_done,
  output logic                             pixel_valid,
  input  logic                             pixel_ready,
  output logic [width_of(IMG_W)-1:0]       pixel_counter_x,
  output logic [width_of(IMG_H)-1:0]       pixel_counter_y,
  output logic                             last_pixel,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output state_t                           fsm_state
);

  localparam int PW  = width_of(SHIFT_POS);
  localparam int WCW = width_of(max_of(ACK_TIMEOUT, SETTLE_CYCLES));
  localparam logic [PW-1:0]  POS_LAST   = PW'(SHIFT_POS - 1);
  localparam logic [PW-1:0]  POS_ONE    = PW'(1);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
  localparam logic [WCW-1:0] SETTLE_END = WCW'(SETTLE_CYCLES - 1);
  localparam logic [WCW-1:0] TIMEOUT_END = WCW'(ACK_TIMEOUT - 1);

  state_t          state;
  logic [PW-1:0]   index;
  logic [WCW-1:0]  wait_cnt;
  logic            frame_last;
  logic            xfer;
  logic            raster_clear;

  // A pixel counts only when the handshake completes and no abort overrides it.
  assign xfer         = pixel_valid & pixel_ready & ~abort;
  assign raster_clear = abort | (state == IDLE);

  raster_counter #(
    .W (IMG_W),
    .H (IMG_H)
  ) u_raster (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (raster_clear),
    .enable  (xfer),
    .x       (pixel_counter_x),
    .y       (pixel_counter_y),
    .last    (frame_last)
  );

  assign shift_pos  = index;
  assign last_pixel = pixel_valid & frame_last;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

  // Sequencer FSM with the shared wait/timeout counter and position index.
  // wait_cnt is zeroed on every state entry and only runs in the waiting states.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      index         <= '0;
      wait_cnt      <= '0;
      shift_req     <= 1'b0;
      capture_start <= 1'b0;
      pixel_valid   <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      capture_start <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        index       <= '0;
        wait_cnt    <= '0;
        shift_req   <= 1'b0;
        pixel_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= MOVE;
              index     <= '0;
              wait_cnt  <= '0;
              error     <= 1'b0;
              shift_req <= 1'b1;
            end
          end
          MOVE: begin
            if (shift_ack) begin
              state     <= SETTLE;
              shift_req <= 1'b0;
              wait_cnt  <= '0;
            end else if (wait_cnt == TIMEOUT_END) begin
              state     <= IDLE;
              shift_req <= 1'b0;
              error     <= 1'b1;
              index     <= '0;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
          end
          SETTLE: begin
            if (wait_cnt == SETTLE_END) begin
              state         <= CAPTURE;
              capture_start <= 1'b1;
              wait_cnt      <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
          end
          CAPTURE: begin
            if (capture_done) begin
              state       <= STREAM;
              pixel_valid <= 1'b1;
              wait_cnt    <= '0;
            end else if (wait_cnt == TIMEOUT_END) begin
              state    <= IDLE;
              error    <= 1'b1;
              index    <= '0;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
          end
          STREAM: begin
            if (xfer && frame_last) begin
              state       <= NEXT;
              pixel_valid <= 1'b0;
            end
          end
          NEXT: begin
            if (index == POS_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= MOVE;
              index     <= index + POS_ONE;
              wait_cnt  <= '0;
              shift_req <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            index <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
